axi_lite_arbiter_2to1: RTL
==========================

Name: axi_lite_arbiter_2to1

Overview:
Two-master to one-slave AXI-lite arbiter.
- Lets the IFU (m0) and the LSU (m1) share the single AXI-lite memory slave (SRAM bridge).
- Grants the bus to one master for one whole transaction (read or write), then re-arbitrates round-robin.
- Sits between the core's fetch/load-store units and the memory-side AXI-lite slave.

Parameters:
ADDR_W, 32, address width of all channels
DATA_W, 32, data width; strobe width is DATA_W/8
INIT_LAST, 1, initial value of the last-granted pointer; 1 means m0 wins the first tie

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low (asserted when 0)
m0  axi_lite_if.slave  bundle  IFU-side AXI-lite port (ar/r/aw/w/b channels)
m1  axi_lite_if.slave  bundle  LSU-side AXI-lite port
s  axi_lite_if.master  bundle  downstream port to the memory slave
grant_o  output  2  one-hot current owner {m1,m0}; 2'b00 when idle (debug/perf)

Behaviour:
- State: IDLE, RD, WR. Registers: owner (1 bit), last (1 bit), ar_done, aw_done, w_done.
- Reset (rst==0, async):
  - state=IDLE, owner=0, last=INIT_LAST, all done flags=0.
  - All valid/ready outputs on m0, m1 and s are 0; data/resp outputs are 0; grant_o=0.
- Per-master request: req_i = arvalid | awvalid | wvalid.
- IDLE:
  - No readies to any master; s valids are 0.
  - One requester: grant it. Both requesting: grant ~last.
  - Next state is RD if the granted master's arvalid=1, otherwise WR. Read beats write within a master.
  - Grant is registered, so one cycle is spent in IDLE. Minimum added latency is 1 cycle per transaction.
- RD, owner o:
  - s.araddr = mo.araddr. s.arvalid = mo.arvalid & ~ar_done. mo.arready = s.arready & ~ar_done.
  - ar_done is set on the s ar handshake.
  - r channel passes combinationally: s.rvalid/rdata/rresp go to mo, and mo.rready goes to s.
  - On the r handshake (s.rvalid & s.rready): state=IDLE, last=o, ar_done cleared.
- WR, owner o:
  - aw and w are forwarded independently, each gated by its own done flag, as in RD. Either may complete first or in the same cycle.
  - b channel passes combinationally.
  - s.bvalid is accepted toward mo only once aw_done|aw handshake and w_done|w handshake have both occurred.
  - On the b handshake: state=IDLE, last=o, aw_done and w_done cleared.
- Non-owner master, all states: arready=awready=wready=rvalid=bvalid=0. Its valids are held pending and it is never dropped.
- Fairness:
  - A master requesting continuously waits at most one transaction of the other master.
  - After a read, the same master's pending write competes again in IDLE.
- grant_o = (state!=IDLE) ? one-hot(owner) : 0.
- Reset asserted mid-transaction: returns to IDLE immediately, with no completion to either master. The slave is reset by the same rst.
- Invalid state encoding: go to IDLE.
- No combinational path from m*.valid to m*.ready in IDLE.

Test Plan:
- Reset and idle:
  - Stimulus: rst=0, then release; no requests.
  - Required: all readies and valids 0, grant_o=0 on every cycle.
- Single read:
  - Stimulus: m0 reads 0x8000_0000; slave returns 0x1234_5678 with OKAY.
  - Required: grant_o=01 one cycle after arvalid; m0 gets rdata 0x1234_5678, rresp 0; back to IDLE after the rready handshake.
- Simultaneous requests:
  - Stimulus: m0 read and m1 write (addr 0x8000_0010, data 0xDEAD_BEEF, wstrb 0xF) asserted on the same cycle after reset.
  - Required: m0 served first (INIT_LAST=1), then m1; slave sees the write with the exact values; m1 bresp 0.
- Round-robin:
  - Stimulus: both masters issue 4 back-to-back reads each.
  - Required: grant order m0,m1,m0,m1,...; neither master waits more than one transaction.
- Write channel ordering:
  - Stimulus: m1 presents wvalid 3 cycles before awvalid; slave holds awready low 2 extra cycles.
  - Required: each channel is handshaken exactly once; bvalid reaches m1 only after both; m0 stays blocked until b completes.
- Backpressure and mid-transaction reset:
  - Stimulus: m0 holds rready=0 for 5 cycles, then rst pulses low while in RD.
  - Required: rvalid is held stable; after reset, state=IDLE, grant_o=0, and m0 sees no r handshake.

Source files
------------

// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI-lite bundle shared by the arbiter's two upstream ports and its
// downstream port. "master" drives requests, "slave" answers them.
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Two-master (IFU on m0, LSU on m1) to one-slave AXI-lite arbiter.
// One whole read or write transaction is granted at a time; ownership is
// decided in a registered IDLE cycle and rotates round-robin between masters.
module axi_lite_arbiter_2to1 #(
    parameter int   ADDR_W    = 32,
    parameter int   DATA_W    = 32,
    parameter logic INIT_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    axi_lite_if.slave  m0,
    axi_lite_if.slave  m1,
    axi_lite_if.master s,
    output logic [1:0] grant_o
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    // Requests and round-robin pick (only used while IDLE)
    logic req0, req1, gnt_pick;
    assign req0     = m0.arvalid | m0.awvalid | m0.wvalid;
    assign req1     = m1.arvalid | m1.awvalid | m1.wvalid;
    assign gnt_pick = (req0 & req1) ? ~last_q : req1;

    // Request-side signals of whichever master currently owns the bus
    logic [ADDR_W-1:0] sel_araddr, sel_awaddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;
    assign sel_araddr  = owner_q ? m1.araddr  : m0.araddr;
    assign sel_arvalid = owner_q ? m1.arvalid : m0.arvalid;
    assign sel_rready  = owner_q ? m1.rready  : m0.rready;
    assign sel_awaddr  = owner_q ? m1.awaddr  : m0.awaddr;
    assign sel_awvalid = owner_q ? m1.awvalid : m0.awvalid;
    assign sel_wdata   = owner_q ? m1.wdata   : m0.wdata;
    assign sel_wstrb   = owner_q ? m1.wstrb   : m0.wstrb;
    assign sel_wvalid  = owner_q ? m1.wvalid  : m0.wvalid;
    assign sel_bready  = owner_q ? m1.bready  : m0.bready;

    // Downstream drive and response-side signals headed to the owner
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic              fwd_arready, fwd_rvalid, fwd_awready, fwd_wready, fwd_bvalid;
    logic [DATA_W-1:0] fwd_rdata;
    logic [1:0]        fwd_rresp, fwd_bresp;
    logic              aw_hs, w_hs, b_open;

    // Next-state, done-flag bookkeeping and channel routing
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        ar_done_d   = ar_done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        fwd_arready = 1'b0;
        fwd_rvalid  = 1'b0;
        fwd_rdata   = '0;
        fwd_rresp   = '0;
        fwd_awready = 1'b0;
        fwd_wready  = 1'b0;
        fwd_bvalid  = 1'b0;
        fwd_bresp   = '0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_open      = 1'b0;
        case (state_q)
            IDLE: begin
                // Nothing is forwarded here, so no valid->ready path exists
                if (req0 | req1) begin
                    owner_d = gnt_pick;
                    state_d = (gnt_pick ? m1.arvalid : m0.arvalid) ? RD : WR;
                end
            end
            RD: begin
                s_araddr    = sel_araddr;
                s_arvalid   = sel_arvalid & ~ar_done_q;
                fwd_arready = s.arready & ~ar_done_q;
                fwd_rvalid  = s.rvalid;
                fwd_rdata   = s.rdata;
                fwd_rresp   = s.rresp;
                s_rready    = sel_rready;
                if (s_arvalid & s.arready) begin
                    ar_done_d = 1'b1;
                end
                if (s.rvalid & sel_rready) begin
                    state_d   = IDLE;
                    last_d    = owner_q;
                    ar_done_d = 1'b0;
                end
            end
            WR: begin
                s_awaddr    = sel_awaddr;
                s_awvalid   = sel_awvalid & ~aw_done_q;
                fwd_awready = s.awready & ~aw_done_q;
                s_wdata     = sel_wdata;
                s_wstrb     = sel_wstrb;
                s_wvalid    = sel_wvalid & ~w_done_q;
                fwd_wready  = s.wready & ~w_done_q;
                aw_hs       = s_awvalid & s.awready;
                w_hs        = s_wvalid & s.wready;
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                // The response is only passed once both address and data are in
                b_open      = (aw_done_q | aw_hs) & (w_done_q | w_hs);
                fwd_bvalid  = s.bvalid & b_open;
                fwd_bresp   = s.bresp;
                s_bready    = sel_bready & b_open;
                if (s.bvalid & s_bready) begin
                    state_d   = IDLE;
                    last_d    = owner_q;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // Arbiter state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= INIT_LAST;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign s.araddr  = s_araddr;
    assign s.arvalid = s_arvalid;
    assign s.rready  = s_rready;
    assign s.awaddr  = s_awaddr;
    assign s.awvalid = s_awvalid;
    assign s.wdata   = s_wdata;
    assign s.wstrb   = s_wstrb;
    assign s.wvalid  = s_wvalid;
    assign s.bready  = s_bready;

    // The non-owner always sees idle response channels
    assign m0.arready = fwd_arready & ~owner_q;
    assign m0.rvalid  = fwd_rvalid  & ~owner_q;
    assign m0.rdata   = owner_q ? '0 : fwd_rdata;
    assign m0.rresp   = owner_q ? '0 : fwd_rresp;
    assign m0.awready = fwd_awready & ~owner_q;
    assign m0.wready  = fwd_wready  & ~owner_q;
    assign m0.bvalid  = fwd_bvalid  & ~owner_q;
    assign m0.bresp   = owner_q ? '0 : fwd_bresp;

    assign m1.arready = fwd_arready & owner_q;
    assign m1.rvalid  = fwd_rvalid  & owner_q;
    assign m1.rdata   = owner_q ? fwd_rdata : '0;
    assign m1.rresp   = owner_q ? fwd_rresp : '0;
    assign m1.awready = fwd_awready & owner_q;
    assign m1.wready  = fwd_wready  & owner_q;
    assign m1.bvalid  = fwd_bvalid  & owner_q;
    assign m1.bresp   = owner_q ? fwd_bresp : '0;

    assign grant_o = (state_q == RD || state_q == WR) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
endmodule
